// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the byte-serial memory controller.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam logic [1:0] LenByte     = 2'b00;
    localparam logic [1:0] LenHalf     = 2'b01;
    localparam logic [1:0] LenWord     = 2'b10;
    localparam logic       ResetEnable = 1'b0;

    function automatic logic [2:0] beats(input logic [1:0] len);
        case (len)
            LenByte: beats = 3'd1;
            LenHalf: beats = 3'd2;
            default: beats = 3'd4;
        endcase
    endfunction

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [2:0] k);
        case (k)
            3'd0:    byte_sel = w[7:0];
            3'd1:    byte_sel = w[15:8];
            3'd2:    byte_sel = w[23:16];
            3'd3:    byte_sel = w[31:24];
            default: byte_sel = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_extend.sv
// Load-data extension: byte/half sign- or zero-extended, word passed through.
module mem_ctrl_extend
    import mem_ctrl_pkg::*;
(
    input  logic [1:0]  len,
    input  logic        sext,
    input  logic [31:0] raw,
    output logic [31:0] ext
);

    // Select extension width from the access length
    always_comb begin
        ext = raw;
        case (len)
            LenByte: ext = {{24{sext & raw[7]}}, raw[7:0]};
            LenHalf: ext = {{16{sext & raw[15]}}, raw[15:0]};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller: arbitrates IF/MEM, splits accesses into
// little-endian byte beats and reassembles read data.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_done,
    output logic [DATA_W-1:0] if_data,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic              mem_sext,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_done,
    output logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
);

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              own_mem_q, own_mem_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [1:0]        len_q, len_d;
    logic              we_q, we_d, sext_q, sext_d, flush_q, flush_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, raw_q, raw_d;
    logic              if_done_q, if_done_d, mem_done_q, mem_done_d, ram_wr_q, ram_wr_d;
    logic [DATA_W-1:0] if_data_q, if_data_d, mem_rdata_q, mem_rdata_d;
    logic [ADDR_W-1:0] ram_a_q, ram_a_d;
    logic [7:0]        ram_dout_q, ram_dout_d;

    logic [2:0]        n_s, nxt_s;
    logic [DATA_W-1:0] raw_upd_s, ext_s;
    logic              finish_s;

    assign n_s   = beats(len_q);
    assign nxt_s = cnt_q + 3'd1;

    // Read byte k arrives while cnt_q == k+1; merge it into its lane
    always_comb begin
        raw_upd_s = raw_q;
        case (cnt_q)
            3'd1:    raw_upd_s[7:0]   = ram_din;
            3'd2:    raw_upd_s[15:8]  = ram_din;
            3'd3:    raw_upd_s[23:16] = ram_din;
            3'd4:    raw_upd_s[31:24] = ram_din;
            default: raw_upd_s        = raw_q;
        endcase
    end

    mem_ctrl_extend u_extend (
        .len  (len_q),
        .sext (sext_q),
        .raw  (raw_upd_s),
        .ext  (ext_s)
    );

    // Writes finish after the last beat, reads one cycle later with the last byte
    assign finish_s = we_q ? (cnt_q == (n_s - 3'd1)) : (cnt_q == n_s);

    // Next-state and next-output computation
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        own_mem_d   = own_mem_q;
        base_d      = base_q;
        len_d       = len_q;
        we_d        = we_q;
        sext_d      = sext_q;
        flush_d     = flush_q;
        wdata_d     = wdata_q;
        raw_d       = raw_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        ram_wr_d    = 1'b0;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        ram_a_d     = ram_a_q;
        ram_dout_d  = ram_dout_q;
        case (state_q)
            ST_IDLE: begin
                if (rdy && (mem_req || if_req)) begin
                    state_d    = ST_BUSY;
                    cnt_d      = 3'd0;
                    own_mem_d  = mem_req;
                    base_d     = mem_req ? mem_addr : if_addr;
                    len_d      = mem_req ? mem_len : LenWord;
                    we_d       = mem_req & mem_we;
                    sext_d     = mem_req & mem_sext;
                    wdata_d    = mem_req ? mem_wdata : {DATA_W{1'b0}};
                    raw_d      = {DATA_W{1'b0}};
                    flush_d    = 1'b0;
                    ram_a_d    = mem_req ? mem_addr : if_addr;
                    ram_wr_d   = mem_req & mem_we;
                    ram_dout_d = mem_req ? mem_wdata[7:0] : 8'h00;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                cnt_d   = nxt_s;
                raw_d   = raw_upd_s;
                flush_d = flush_q | (~own_mem_q & if_flush);
                if (nxt_s < n_s) begin
                    ram_a_d    = base_q + ADDR_W'(nxt_s);
                    ram_wr_d   = we_q;
                    ram_dout_d = byte_sel(wdata_q, nxt_s);
                end else begin
                    ram_wr_d = 1'b0;
                end
                if (finish_s) begin
                    if (own_mem_q) begin
                        state_d     = ST_DONE;
                        mem_done_d  = 1'b1;
                        mem_rdata_d = we_q ? mem_rdata_q : ext_s;
                    end else if (flush_d) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_DONE;
                        if_done_d = 1'b1;
                        if_data_d = raw_upd_s;
                    end
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (rst == ResetEnable) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            own_mem_q   <= 1'b0;
            base_q      <= {ADDR_W{1'b0}};
            len_q       <= 2'b00;
            we_q        <= 1'b0;
            sext_q      <= 1'b0;
            flush_q     <= 1'b0;
            wdata_q     <= {DATA_W{1'b0}};
            raw_q       <= {DATA_W{1'b0}};
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            ram_wr_q    <= 1'b0;
            if_data_q   <= {DATA_W{1'b0}};
            mem_rdata_q <= {DATA_W{1'b0}};
            ram_a_q     <= {ADDR_W{1'b0}};
            ram_dout_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            own_mem_q   <= own_mem_d;
            base_q      <= base_d;
            len_q       <= len_d;
            we_q        <= we_d;
            sext_q      <= sext_d;
            flush_q     <= flush_d;
            wdata_q     <= wdata_d;
            raw_q       <= raw_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            ram_wr_q    <= ram_wr_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
            ram_a_q     <= ram_a_d;
            ram_dout_q  <= ram_dout_d;
        end
    end

    assign if_done   = if_done_q;
    assign if_data   = if_data_q;
    assign mem_done  = mem_done_q;
    assign mem_rdata = mem_rdata_q;
    assign ram_a     = ram_a_q;
    assign ram_wr    = ram_wr_q;
    assign ram_dout  = ram_dout_q;

endmodule
